// File: rtl/intercal_alu_host.sv
// Host-side initiator for the intercal ALU tile: loads A/B over eight byte
// writes, selects the opcode, reads back four result bytes, returns the word.
module intercal_alu_host #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  input  logic [3:0]  i_req_op,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_f,
  output logic [7:0]  o_alu_ui,
  output logic [7:0]  o_alu_uio_out,
  output logic        o_alu_uio_oe,
  input  logic [7:0]  i_alu_dout
);

  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = 8;
  localparam int unsigned OPW   = 4;
  localparam int unsigned IDXW  = 3;
  localparam int unsigned SELW  = 2;
  localparam int unsigned WAITW = 3;
  localparam int unsigned RESW  = 24;

  // ui[7]=1 blocks tile writes, ui[6]=1 keeps the tile's uio as input
  localparam logic [BW-1:0] UI_IDLE = 8'hC0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RESP
  } state_t;

  state_t           r_state, w_state;
  logic [DW-1:0]    r_a, w_a;
  logic [DW-1:0]    r_b, w_b;
  logic [OPW-1:0]   r_op, w_op;
  logic [IDXW-1:0]  r_idx, w_idx;
  logic [SELW-1:0]  r_sel, w_sel;
  logic [WAITW-1:0] r_wait, w_wait;
  logic [RESW-1:0]  r_res, w_res;
  logic [BW-1:0]    r_alu_ui, w_alu_ui;
  logic [BW-1:0]    r_alu_uio_out, w_alu_uio_out;
  logic             r_alu_uio_oe, w_alu_uio_oe;
  logic             r_resp_valid, w_resp_valid;
  logic [DW-1:0]    r_resp_f, w_resp_f;
  logic             r_req_ready, w_req_ready;
  logic [2*DW-1:0]  w_ops;

  assign o_req_ready   = r_req_ready;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_f      = r_resp_f;
  assign o_alu_ui      = r_alu_ui;
  assign o_alu_uio_out = r_alu_uio_out;
  assign o_alu_uio_oe  = r_alu_uio_oe;

  // State and registered-output update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_op          <= '0;
      r_idx         <= '0;
      r_sel         <= '0;
      r_wait        <= '0;
      r_res         <= '0;
      r_alu_ui      <= UI_IDLE;
      r_alu_uio_out <= '0;
      r_alu_uio_oe  <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_f      <= '0;
      r_req_ready   <= 1'b1;
    end else begin
      r_state       <= w_state;
      r_a           <= w_a;
      r_b           <= w_b;
      r_op          <= w_op;
      r_idx         <= w_idx;
      r_sel         <= w_sel;
      r_wait        <= w_wait;
      r_res         <= w_res;
      r_alu_ui      <= w_alu_ui;
      r_alu_uio_out <= w_alu_uio_out;
      r_alu_uio_oe  <= w_alu_uio_oe;
      r_resp_valid  <= w_resp_valid;
      r_resp_f      <= w_resp_f;
      r_req_ready   <= w_req_ready;
    end
  end

  // Next state plus next value of every pin, so pins change with the state
  always_comb begin
    w_state       = r_state;
    w_a           = r_a;
    w_b           = r_b;
    w_op          = r_op;
    w_idx         = r_idx;
    w_sel         = r_sel;
    w_wait        = r_wait;
    w_res         = r_res;
    w_alu_ui      = r_alu_ui;
    w_alu_uio_out = r_alu_uio_out;
    w_alu_uio_oe  = r_alu_uio_oe;
    w_resp_valid  = r_resp_valid;
    w_resp_f      = r_resp_f;
    w_ops         = {r_b, r_a};

    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_state       = WRITE;
          w_a           = i_req_a;
          w_b           = i_req_b;
          w_op          = i_req_op;
          w_idx         = '0;
          w_alu_ui      = {2'b01, 3'b000, 3'd0};
          w_alu_uio_out = i_req_a[BW-1:0];
          w_alu_uio_oe  = 1'b1;
        end
      end

      WRITE: begin
        if (r_idx == IDXW'(7)) begin
          w_state       = READ;
          w_sel         = '0;
          w_wait        = '0;
          w_alu_ui      = {2'b11, r_op, 2'b00};
          w_alu_uio_out = '0;
          w_alu_uio_oe  = 1'b0;
        end else begin
          w_idx         = r_idx + IDXW'(1);
          w_alu_ui      = {2'b01, 3'b000, w_idx};
          w_alu_uio_out = w_ops[{w_idx, 3'b000} +: BW];
        end
      end

      READ: begin
        if (r_wait == WAITW'(SETTLE)) begin
          case (r_sel)
            2'd0:    w_res[7:0]   = i_alu_dout;
            2'd1:    w_res[15:8]  = i_alu_dout;
            2'd2:    w_res[23:16] = i_alu_dout;
            default: w_res        = r_res;
          endcase
          if (r_sel == SELW'(3)) begin
            w_state      = RESP;
            w_resp_f     = {i_alu_dout, r_res};
            w_resp_valid = 1'b1;
            w_alu_ui     = UI_IDLE;
          end else begin
            w_sel    = r_sel + SELW'(1);
            w_wait   = '0;
            w_alu_ui = {2'b11, r_op, w_sel};
          end
        end else begin
          w_wait = r_wait + WAITW'(1);
        end
      end

      RESP: begin
        if (i_resp_ready) begin
          w_state      = IDLE;
          w_resp_valid = 1'b0;
        end
      end

      default: w_state = IDLE;
    endcase

    w_req_ready = (w_state == IDLE);
  end

endmodule
